// File: rtl/tri_edge_sequencer_if.sv
// rtl/tri_edge_sequencer_if.sv - RAM read port and line rasterizer handshake bundle
//
// Signals:
//   ram_read_addr        base address of the current triangle record (sequencer -> RAM)
//   ram_read_data1..9    RAM words at ram_read_addr+0..+8: x0,y0,c0,x1,y1,c1,x2,y2,c2
//   line_start           one-cycle edge command pulse (sequencer -> rasterizer)
//   line_x0/y0/x1/y1     edge endpoints
//   line_color           colour of the edge's start vertex
//   line_done            one-cycle edge completion pulse (rasterizer -> sequencer)
// Modports: master = sequencer side, slave = RAM/rasterizer side.

interface tri_edge_sequencer_if #(
    parameter int addr_width  = 8,
    parameter int data_width  = 32,
    parameter int coord_width = 10
);
    logic [addr_width-1:0]  ram_read_addr;
    logic [data_width-1:0]  ram_read_data1;
    logic [data_width-1:0]  ram_read_data2;
    logic [data_width-1:0]  ram_read_data3;
    logic [data_width-1:0]  ram_read_data4;
    logic [data_width-1:0]  ram_read_data5;
    logic [data_width-1:0]  ram_read_data6;
    logic [data_width-1:0]  ram_read_data7;
    logic [data_width-1:0]  ram_read_data8;
    logic [data_width-1:0]  ram_read_data9;
    logic                   line_start;
    logic [coord_width-1:0] line_x0;
    logic [coord_width-1:0] line_y0;
    logic [coord_width-1:0] line_x1;
    logic [coord_width-1:0] line_y1;
    logic [coord_width-1:0] line_color;
    logic                   line_done;

    modport master (
        output ram_read_addr,
        input  ram_read_data1, ram_read_data2, ram_read_data3,
        input  ram_read_data4, ram_read_data5, ram_read_data6,
        input  ram_read_data7, ram_read_data8, ram_read_data9,
        output line_start, line_x0, line_y0, line_x1, line_y1, line_color,
        input  line_done
    );

    modport slave (
        input  ram_read_addr,
        output ram_read_data1, ram_read_data2, ram_read_data3,
        output ram_read_data4, ram_read_data5, ram_read_data6,
        output ram_read_data7, ram_read_data8, ram_read_data9,
        input  line_start, line_x0, line_y0, line_x1, line_y1, line_color,
        output line_done
    );
endinterface

// File: rtl/tri_edge_sequencer.sv
// rtl/tri_edge_sequencer.sv - fetches triangle records and issues three edge commands per triangle
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   load_finish  loader finish level; high = RAM contents valid
//   bus          master side of tri_edge_sequencer_if (RAM read port + line handshake)
//   busy         high in every state except IDLE and DONE
//   frame_done   high and held once the last edge of the last triangle has completed

module tri_edge_sequencer #(
    parameter int addr_width  = 8,
    parameter int data_width  = 32,
    parameter int coord_width = 10,
    parameter int num_tris    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_finish,
    tri_edge_sequencer_if.master  bus,
    output logic                  busy,
    output logic                  frame_done
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LATCH,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [addr_width-1:0] LAST_TRI = addr_width'(num_tris - 1);

    state_t                                 state_q, state_d;
    logic [addr_width-1:0]                  tri_q, tri_d;
    logic [1:0]                             edge_q, edge_d;
    logic [2:0][coord_width-1:0]            vx_q, vx_d;
    logic [2:0][coord_width-1:0]            vy_q, vy_d;
    logic [coord_width-1:0]                 c1_q, c1_d;
    logic [coord_width-1:0]                 c2_q, c2_d;
    logic [coord_width-1:0]                 lx0_q, lx0_d;
    logic [coord_width-1:0]                 ly0_q, ly0_d;
    logic [coord_width-1:0]                 lx1_q, lx1_d;
    logic [coord_width-1:0]                 ly1_q, ly1_d;
    logic [coord_width-1:0]                 lc_q, lc_d;

    // Only the low coord_width bits of each RAM word carry geometry.
    logic unused_hi;
    assign unused_hi = ^{bus.ram_read_data1[data_width-1:coord_width],
                         bus.ram_read_data2[data_width-1:coord_width],
                         bus.ram_read_data3[data_width-1:coord_width],
                         bus.ram_read_data4[data_width-1:coord_width],
                         bus.ram_read_data5[data_width-1:coord_width],
                         bus.ram_read_data6[data_width-1:coord_width],
                         bus.ram_read_data7[data_width-1:coord_width],
                         bus.ram_read_data8[data_width-1:coord_width],
                         bus.ram_read_data9[data_width-1:coord_width]};

    always_comb begin
        state_d = state_q;
        tri_d   = tri_q;
        edge_d  = edge_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        lx0_d   = lx0_q;
        ly0_d   = ly0_q;
        lx1_d   = lx1_q;
        ly1_d   = ly1_q;
        lc_d    = lc_q;
        case (state_q)
            S_IDLE: begin
                if (load_finish) begin
                    tri_d   = '0;
                    state_d = S_ADDR;
                end
            end
            // Address has been driven from tri_q for a full cycle before LATCH samples,
            // which covers both async-read and registered-read RAMs.
            S_ADDR: state_d = S_LATCH;
            S_LATCH: begin
                vx_d[0] = bus.ram_read_data1[coord_width-1:0];
                vy_d[0] = bus.ram_read_data2[coord_width-1:0];
                vx_d[1] = bus.ram_read_data4[coord_width-1:0];
                vy_d[1] = bus.ram_read_data5[coord_width-1:0];
                c1_d    = bus.ram_read_data6[coord_width-1:0];
                vx_d[2] = bus.ram_read_data7[coord_width-1:0];
                vy_d[2] = bus.ram_read_data8[coord_width-1:0];
                c2_d    = bus.ram_read_data9[coord_width-1:0];
                // Edge 0 is loaded straight from the RAM words so it is ready in ISSUE;
                // c0 is never needed again, so it is not kept in the vertex store.
                lx0_d   = bus.ram_read_data1[coord_width-1:0];
                ly0_d   = bus.ram_read_data2[coord_width-1:0];
                lx1_d   = bus.ram_read_data4[coord_width-1:0];
                ly1_d   = bus.ram_read_data5[coord_width-1:0];
                lc_d    = bus.ram_read_data3[coord_width-1:0];
                edge_d  = 2'd0;
                state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.line_done) begin
                    if (edge_q == 2'd2) begin
                        state_d = S_NEXT;
                    end else begin
                        edge_d  = edge_q + 2'd1;
                        state_d = S_ISSUE;
                        if (edge_q == 2'd0) begin
                            lx0_d = vx_q[1];
                            ly0_d = vy_q[1];
                            lx1_d = vx_q[2];
                            ly1_d = vy_q[2];
                            lc_d  = c1_q;
                        end else begin
                            lx0_d = vx_q[2];
                            ly0_d = vy_q[2];
                            lx1_d = vx_q[0];
                            ly1_d = vy_q[0];
                            lc_d  = c2_q;
                        end
                    end
                end
            end
            S_NEXT: begin
                if (tri_q == LAST_TRI) begin
                    state_d = S_DONE;
                end else begin
                    tri_d   = tri_q + addr_width'(1);
                    state_d = S_ADDR;
                end
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tri_q   <= '0;
            edge_q  <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            lx0_q   <= '0;
            ly0_q   <= '0;
            lx1_q   <= '0;
            ly1_q   <= '0;
            lc_q    <= '0;
        end else begin
            state_q <= state_d;
            tri_q   <= tri_d;
            edge_q  <= edge_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            lx0_q   <= lx0_d;
            ly0_q   <= ly0_d;
            lx1_q   <= lx1_d;
            ly1_q   <= ly1_d;
            lc_q    <= lc_d;
        end
    end

    // All outputs are decoded from registers only; no input reaches an output combinationally.
    assign bus.ram_read_addr = tri_q * addr_width'(9);
    assign bus.line_start    = (state_q == S_ISSUE);
    assign bus.line_x0       = lx0_q;
    assign bus.line_y0       = ly0_q;
    assign bus.line_x1       = lx1_q;
    assign bus.line_y1       = ly1_q;
    assign bus.line_color    = lc_q;
    assign busy              = (state_q != S_IDLE) && (state_q != S_DONE);
    assign frame_done        = (state_q == S_DONE);
endmodule
